// File: rtl/arbiter.sv
// Three-channel packet arbiter feeding the formatter.
// Picks one channel per packet by priority (0 = highest), with round-robin
// among equal priorities. Streams one packet of that channel's words to the
// formatter and holds the channel id until the formatter asks for the next id.
module arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              slv0_en_i,
  input  logic [1:0]        slv0_prio_i,
  input  logic              slv0_req_i,
  input  logic              slv0_val_i,
  input  logic [DATA_W-1:0] slv0_data_i,
  output logic              slv0_ack_o,
  input  logic              slv1_en_i,
  input  logic [1:0]        slv1_prio_i,
  input  logic              slv1_req_i,
  input  logic              slv1_val_i,
  input  logic [DATA_W-1:0] slv1_data_i,
  output logic              slv1_ack_o,
  input  logic              slv2_en_i,
  input  logic [1:0]        slv2_prio_i,
  input  logic              slv2_req_i,
  input  logic              slv2_val_i,
  input  logic [DATA_W-1:0] slv2_data_i,
  output logic              slv2_ack_o,
  input  logic [2:0]        pkglen_sel_i,
  input  logic              fmt_id_req_i,
  input  logic              f2a_ack_i,
  output logic [1:0]        a2f_id_o,
  output logic              a2f_val_o,
  output logic [DATA_W-1:0] a2f_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_HOLD} state_t;

  state_t            r_state;
  logic [1:0]        r_id;
  logic [1:0]        r_last;
  logic [5:0]        r_len;
  logic [5:0]        r_cnt;
  logic              r_val;
  logic [DATA_W-1:0] r_data;

  // Slave signals gathered into arrays; index 3 is the "no channel" slot so
  // indexing by the 2-bit id never falls off the end.
  logic [2:0]        w_cand;
  logic [3:0]        w_vld;
  logic [1:0]        w_prio [3];
  logic [DATA_W-1:0] w_dat  [4];
  logic [1:0]        w_min;
  logic [1:0]        w_win;
  logic [1:0]        w_ch;
  logic              w_found;
  logic              w_pop;
  logic [5:0]        w_len_dec;

  assign w_cand    = {slv2_en_i & slv2_req_i, slv1_en_i & slv1_req_i, slv0_en_i & slv0_req_i};
  assign w_vld     = {1'b0, slv2_val_i, slv1_val_i, slv0_val_i};
  assign w_prio[0] = slv0_prio_i;
  assign w_prio[1] = slv1_prio_i;
  assign w_prio[2] = slv2_prio_i;
  assign w_dat[0]  = slv0_data_i;
  assign w_dat[1]  = slv1_data_i;
  assign w_dat[2]  = slv2_data_i;
  assign w_dat[3]  = '0;

  function automatic logic [1:0] nxt(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  // Winner: lowest priority value among candidates, ties broken by a
  // round-robin search starting just after the last granted channel.
  always_comb begin
    w_min   = 2'd3;
    w_win   = 2'd0;
    w_found = 1'b0;
    for (int i = 0; i < 3; i++)
      if (w_cand[i] && (w_prio[i] < w_min)) w_min = w_prio[i];
    w_ch = nxt(r_last);
    for (int k = 0; k < 3; k++) begin
      if (!w_found && w_cand[w_ch] && (w_prio[w_ch] == w_min)) begin
        w_win   = w_ch;
        w_found = 1'b1;
      end
      w_ch = nxt(w_ch);
    end
  end

  // Packet length decode, only sampled at selection.
  always_comb begin
    case (pkglen_sel_i)
      3'd0:    w_len_dec = 6'd4;
      3'd1:    w_len_dec = 6'd8;
      3'd2:    w_len_dec = 6'd16;
      default: w_len_dec = 6'd32;
    endcase
  end

  // A pop needs the formatter ready and the selected slave's head word valid.
  assign w_pop      = (r_state == S_XFER) & f2a_ack_i & w_vld[r_id];
  assign slv0_ack_o = w_pop & (r_id == 2'd0);
  assign slv1_ack_o = w_pop & (r_id == 2'd1);
  assign slv2_ack_o = w_pop & (r_id == 2'd2);

  assign a2f_id_o   = r_id;
  assign a2f_val_o  = r_val;
  assign a2f_data_o = r_data;

  // Main FSM: IDLE/HOLD arbitrate on an id request, XFER streams one packet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_id    <= 2'd3;
      r_last  <= 2'd2;
      r_len   <= 6'd4;
      r_cnt   <= 6'd0;
      r_val   <= 1'b0;
      r_data  <= '0;
    end else if (r_state != S_XFER) begin
      r_val <= 1'b0;
      if (fmt_id_req_i) begin
        if (|w_cand) begin
          r_id    <= w_win;
          r_last  <= w_win;
          r_len   <= w_len_dec;
          r_cnt   <= 6'd0;
          r_state <= S_XFER;
        end else begin
          r_id    <= 2'd3;
          r_state <= S_IDLE;
        end
      end
    end else begin
      r_val <= w_pop;
      if (w_pop) begin
        r_data <= w_dat[r_id];
        if (r_cnt == r_len - 6'd1) begin
          // Wrap so the count stays within the packet length.
          r_cnt   <= 6'd0;
          r_state <= S_HOLD;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
      end
    end
  end

endmodule
